// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundle between fetch stage, data stage, the port arbiter and external memory.
// Latency: none, signals only.
// Backpressure: core side is held-req / valid-pulse; bus side is held-req / ack.
// Modports:
//   slave  - arbiter view: core requests and bus response in; results, stalls, bus transaction out.
//   master - environment view (pipeline stages plus memory), the mirror image of slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction fetch stage
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              stall_if;

  // Data access stage
  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              stall_mem;

  // External memory port
  logic              bus_req;
  logic              bus_we;
  logic [BE_W-1:0]   bus_be;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, stall_if,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, stall_mem,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_ack
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, stall_if,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, stall_mem,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and data access, data has priority.
// Latency: request seen at cycle N -> bus_req at N+1; ack at cycle A -> *_valid pulse at A+1.
// Backpressure: requesters hold *_req and see stall_* until their valid pulse; a missing ack
//   is cut off after TIMEOUT waiting cycles with bus_err and a zero-data completion.
// Ports:
//   clk, rst (async, active-low)
//   port.slave : if_* fetch side, dm_* data side, bus_* external memory transaction
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,  // 0 disables the timeout
  parameter int TO_W    = 8     // TIMEOUT must fit below 2**TO_W
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  port
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t          state;
  logic            drop;    // current fetch was flushed; finish the bus cycle but hide the result
  logic [TO_W-1:0] toCnt;
  logic            toHit;
  logic            dropNow;

  // The count register lags by one, so the cut-off fires on the edge where the
  // TIMEOUT-th waiting cycle ends; bus_req is therefore high for exactly TIMEOUT cycles.
  assign toHit   = (TIMEOUT != 0) && (toCnt == TO_W'(TIMEOUT - 1)) && !port.bus_ack;
  // A flush landing on the completing cycle still kills that fetch.
  assign dropNow = drop || port.if_flush;

  assign port.stall_if  = port.if_req & ~port.if_valid;
  assign port.stall_mem = port.dm_req & ~port.dm_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      drop           <= 1'b0;
      toCnt          <= '0;
      port.bus_req   <= 1'b0;
      port.bus_we    <= 1'b0;
      port.bus_be    <= '0;
      port.bus_addr  <= ADDR_W'(0);
      port.bus_wdata <= DATA_W'(0);
      port.bus_err   <= 1'b0;
      port.if_rdata  <= DATA_W'(0);
      port.if_valid  <= 1'b0;
      port.dm_rdata  <= DATA_W'(0);
      port.dm_valid  <= 1'b0;
    end else begin
      // Completion and error flags are single-cycle pulses.
      port.if_valid <= 1'b0;
      port.dm_valid <= 1'b0;
      port.bus_err  <= 1'b0;

      case (state)
        IDLE: begin
          // A requester still showing its valid pulse is in its completion cycle and
          // has not yet had a chance to drop or change its request.
          if (port.dm_req && !port.dm_valid) begin
            state          <= DM_BUSY;
            port.bus_req   <= 1'b1;
            port.bus_we    <= port.dm_we;
            port.bus_be    <= port.dm_be;
            port.bus_addr  <= port.dm_addr;
            port.bus_wdata <= port.dm_wdata;
            toCnt          <= '0;
          end else if (port.if_req && !port.if_valid) begin
            state          <= IF_BUSY;
            port.bus_req   <= 1'b1;
            port.bus_we    <= 1'b0;
            port.bus_be    <= '1;
            port.bus_addr  <= port.if_addr;
            port.bus_wdata <= DATA_W'(0);
            toCnt          <= '0;
            drop           <= port.if_flush;
          end
        end

        IF_BUSY: begin
          if (port.bus_ack || toHit) begin
            state        <= IDLE;
            port.bus_req <= 1'b0;
            port.bus_err <= !port.bus_ack;
            drop         <= 1'b0;
            if (!dropNow) begin
              port.if_valid <= 1'b1;
              port.if_rdata <= port.bus_ack ? port.bus_rdata : DATA_W'(0);
            end
          end else begin
            toCnt <= toCnt + 1'b1;
            if (port.if_flush) begin
              drop <= 1'b1;
            end
          end
        end

        DM_BUSY: begin
          if (port.bus_ack || toHit) begin
            state         <= IDLE;
            port.bus_req  <= 1'b0;
            port.bus_err  <= !port.bus_ack;
            port.dm_valid <= 1'b1;
            if (!port.bus_ack) begin
              port.dm_rdata <= DATA_W'(0);
            end else if (!port.bus_we) begin
              port.dm_rdata <= port.bus_rdata;  // stores leave the last load value in place
            end
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          port.bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
